// File: rtl/alu_sequencer.sv
// alu_sequencer: loads B/C/fctn into the ALU, waits SETTLE_CYCLES+1 cycles, captures the result into reg_a/reg_d with Z/C/S flags, and pulses done
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] fctn_code,
  input  logic [7:0] src_b,
  input  logic [7:0] src_c,
  input  logic       dest_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic [7:0] alu_b,
  output logic [7:0] alu_c,
  output logic [2:0] alu_fctn,
  output logic       busy,
  output logic       done,
  output logic [7:0] reg_a,
  output logic [7:0] reg_d,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_s
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, DONE} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic dsel;
  logic [7:0] res;
  always_comb begin
    next = state == IDLE    ? (start ? LOAD : IDLE) :
           state == LOAD    ? SETTLE :
           state == SETTLE  ? (cnt == 4'(SETTLE_CYCLES) ? CAPTURE : SETTLE) :
           state == CAPTURE ? DONE : IDLE;
    res = alu_fctn == 3'b111 ? 8'h00 : alu_result;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next;
      busy  <= next != IDLE;
      done  <= next == DONE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= 4'd0;
      alu_b    <= 8'h00;
      alu_c    <= 8'h00;
      alu_fctn <= 3'b000;
      dsel     <= 1'b0;
      reg_a    <= 8'h00;
      reg_d    <= 8'h00;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_s   <= 1'b0;
    end else begin
      cnt <= state == SETTLE ? cnt + 4'd1 : 4'd0;
      if (state == LOAD) begin
        alu_b    <= src_b;
        alu_c    <= src_c;
        alu_fctn <= fctn_code;
        dsel     <= dest_sel;
      end
      if (state == CAPTURE) begin
        if (dsel) reg_d <= res;
        else reg_a <= res;
        flag_z <= res == 8'h00;
        flag_s <= res[7];
        if (alu_fctn[2:1] == 2'b00) flag_c <= alu_carry;
      end
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 3, the number of clock cycles the ALU inputs are held before the result is sampled (legal range 1..15).
REQ-002 SHALL have the following ports (name, direction, width, meaning):
  clk         in   1  single clock; all state changes on its rising edge
  rst_n       in   1  asynchronous, active-low reset
  start       in   1  request one ALU operation; sampled in IDLE only
  fctn_code   in   3  000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 CLR
  src_b       in   8  B operand, captured in LOAD
  src_c       in   8  C operand, captured in LOAD
  dest_sel    in   1  destination register: 0 = A, 1 = D; captured in LOAD
  alu_result  in   8  result bus returned by the ALU
  alu_carry   in   1  adder carry-out returned by the ALU
  alu_b       out  8  registered B operand driven to the ALU
  alu_c       out  8  registered C operand driven to the ALU
  alu_fctn    out  3  registered function code driven to the ALU
  busy        out  1  high whenever state is not IDLE
  done        out  1  one-cycle pulse; destination register and flags are valid
  reg_a       out  8  destination register A
  reg_d       out  8  destination register D
  flag_z      out  1  zero flag
  flag_c      out  1  carry flag
  flag_s      out  1  sign flag (bit 7 of the result)

Function
REQ-003 SHALL implement a five-state FSM: IDLE, LOAD, SETTLE, CAPTURE, DONE.
REQ-004 In IDLE with start=1, the FSM SHALL go to LOAD; with start=0 it SHALL stay in IDLE.
REQ-005 In LOAD, the block SHALL register src_b->alu_b, src_c->alu_c, fctn_code->alu_fctn and dest_sel, then go to SETTLE.
REQ-006 In SETTLE, a 4-bit counter SHALL count SETTLE_CYCLES cycles, then the FSM SHALL go to CAPTURE.
REQ-007 alu_b, alu_c and alu_fctn SHALL stay stable from the end of LOAD until the FSM returns to IDLE.
REQ-008 In CAPTURE, the block SHALL write alu_result into reg_a (dest_sel=0) or reg_d (dest_sel=1).
REQ-009 Also in CAPTURE: flag_z SHALL be set to (alu_result==0) and flag_s to alu_result[7].
REQ-010 Also in CAPTURE: flag_c SHALL be set to alu_carry for ADD or INC only; for every other code it SHALL hold its previous value.
REQ-011 For CLR (111), the block SHALL write 8'h00 regardless of alu_result, set flag_z=1 and flag_s=0, and hold flag_c.
REQ-012 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-013 Latency: start sampled high at edge N SHALL give done=1 in the cycle after edge N+SETTLE_CYCLES+3.
REQ-014 At that done cycle, the new register and flag values SHALL already be visible.
REQ-015 busy SHALL be 1 in LOAD, SETTLE, CAPTURE and DONE; start SHALL be ignored while busy=1.
REQ-016 A start held high continuously SHALL begin a new operation in the cycle after DONE, giving back-to-back operations with one IDLE cycle between them.
REQ-017 The non-selected destination register SHALL never change.
REQ-018 All state SHALL be registered; outputs SHALL not depend combinationally on inputs.

Reset
REQ-019 On rst_n=0, the block SHALL immediately and asynchronously enter IDLE.
REQ-020 On rst_n=0, the block SHALL clear to 0: the counter, alu_b, alu_c, alu_fctn, reg_a, reg_d, flag_z, flag_c, flag_s, busy and done.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no register or flag update and no done pulse.
REQ-022 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Verification (SETTLE_CYCLES=3, bench ALU model combinational from alu_b/alu_c/alu_fctn)
REQ-023 ADD: B=8'hF0, C=8'h20, dest A -> done 7 cycles after start; reg_a=8'h10, flag_c=1, flag_z=0, flag_s=0; reg_d unchanged.
REQ-024 XOR: B=8'h5A, C=8'h5A, dest D -> reg_d=8'h00, flag_z=1, flag_s=0; flag_c holds 1 from the prior ADD.
REQ-025 CLR while the ALU model drives 8'hFF -> destination=8'h00, flag_z=1, flag_s=0, flag_c unchanged.
REQ-026 start pulsed again during SETTLE -> ignored; exactly one done pulse; alu_b, alu_c and alu_fctn stable throughout.
REQ-027 rst_n pulsed low during SETTLE of an INC with B=8'hFF -> all outputs 0, no done; a following start completes normally.
REQ-028 start held high for 20 cycles -> done pulses exactly every 8 cycles; busy low one cycle between operations.
